pattern_detector_ctrl: RTL and testbench

Configurable controller around a serial overlapping pattern detector. It accepts a pattern, length and match target through a valid/ready config handshake, then scans a qualified serial bit stream on start. It pulses on every match, counts matches, and stops when the target count is reached. It replaces hard-coded sequence detectors, so one block serves every pattern without a respin.

---
 rtl/pdc_pkg.sv | 26 ++
 rtl/pattern_matcher.sv | 52 +++++
 rtl/pattern_detector_ctrl.sv | 133 +++++++++++++
 tb/tb_pattern_detector_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdc_pkg.sv
// rtl/pdc_pkg.sv - shared state encoding, default length and mask helper for the pattern detector
package pdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CONFIGURED = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    localparam int PDC_MAX_LEN = 8;
    localparam int MASK_W      = 16;

    // Mask with the low len bits set; wide enough for the largest legal pattern.
    function automatic logic [MASK_W-1:0] len_mask(input logic [4:0] len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (5'(i) < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// rtl/pattern_matcher.sv - history shift register, saturating seen counter and masked comparator
module pattern_matcher
    import pdc_pkg::*;
#(
    parameter int MAX_LEN = PDC_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic               in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   seen;
    logic [LEN_W:0]     seen_inc;
    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  hist_ext;
    logic [MASK_W-1:0]  pat_ext;

    assign hist_next = {hist[MAX_LEN-2:0], in};
    assign seen_inc  = {1'b0, seen} + 1'b1;
    assign mask      = len_mask(5'(len));
    assign hist_ext  = MASK_W'(hist_next);
    assign pat_ext   = MASK_W'(pattern);

    // Compare against the post-shift history so the match is known in the sampling cycle.
    assign hit = shift
              && (seen_inc >= (LEN_W+1)'(len))
              && (((hist_ext ^ pat_ext) & mask) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            seen <= '0;
        end else if (clear) begin
            hist <= '0;
            seen <= '0;
        end else if (shift) begin
            hist <= hist_next;
            if (seen != LEN_W'(MAX_LEN)) begin
                seen <= seen + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_detector_ctrl.sv
// rtl/pattern_detector_ctrl.sv - config handshake, run control and match counting around pattern_matcher
module pattern_detector_ctrl
    import pdc_pkg::*;
#(
    parameter int MAX_LEN = PDC_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               in,
    input  logic               in_valid,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    state_t state;
    state_t state_nxt;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   tgt_q;

    logic               cfg_fire;
    logic               cfg_len_ok;
    logic               cfg_take;
    logic               cfg_rej;
    logic               run_go;
    logic               shift;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               target_hit;

    assign cfg_ready  = (state != ST_RUN);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign cfg_take   = cfg_fire && cfg_len_ok;
    assign cfg_rej    = cfg_fire && !cfg_len_ok;

    // An accepted config in the same cycle as start takes precedence.
    assign run_go = start && !cfg_take
                 && ((state == ST_CONFIGURED) || (state == ST_DONE));

    assign shift = (state == ST_RUN) && in_valid && !abort;

    assign cnt_inc    = (match_count == '1) ? match_count : match_count + 1'b1;
    assign target_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    pattern_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clock   (clock),
        .reset   (reset),
        .clear   (run_go),
        .shift   (shift),
        .in      (in),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_take) state_nxt = ST_CONFIGURED;
            end
            ST_CONFIGURED: begin
                if (run_go) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)           state_nxt = ST_CONFIGURED;
                else if (target_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (cfg_take)    state_nxt = ST_CONFIGURED;
                else if (run_go) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            len_q <= '0;
            tgt_q <= '0;
        end else if (cfg_take) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            tgt_q <= cfg_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out         <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
        end else begin
            out     <= hit;
            cfg_err <= cfg_rej;
            if (run_go) begin
                match_count <= '0;
            end else if (hit) begin
                match_count <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_pattern_detector_ctrl.sv
// tb/tb_pattern_detector_ctrl.sv - randomized scoreboard bench for pattern_detector_ctrl
module tb_pattern_detector_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int S_IDLE  = 0;
    localparam int S_CONF  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DONE  = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               cfg_err;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               in_bit = 1'b0;
    logic               in_valid = 1'b0;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int exp_cyc_q[$];
    int exp_cnt_q[$];

    int           ms = S_IDLE;
    logic [7:0]   m_pat = '0;
    int           m_len = 0;
    int           m_tgt = 0;
    int           m_cnt = 0;
    bit           m_bits[$];

    pattern_detector_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .in          (in_bit),
        .in_valid    (in_valid),
        .out         (out),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out) begin
            if (exp_cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_spurious: got pulse expected none (cycle %0d)", cyc);
            end else begin
                check("out_cycle", cyc, exp_cyc_q.pop_front());
                check("out_count", int'(match_count), exp_cnt_q.pop_front());
            end
        end
    end

    function automatic bit model_hit();
        int n;
        n = m_bits.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[n-1-i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock of stimulus; the reference model advances alongside it.
    task automatic step(bit cv, logic [7:0] pat, int len, int tgt,
                        bit st, bit ab, bit b, bit v);
        bit ok;
        bit err;
        cfg_valid   = cv;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_target  = CNT_W'(tgt);
        start       = st;
        abort       = ab;
        in_bit      = b;
        in_valid    = v;
        ok  = cv && (ms != S_RUN) && (len >= 1) && (len <= MAX_LEN);
        err = cv && (ms != S_RUN) && !ok;
        if (ok) begin
            m_pat = pat;
            m_len = len;
            m_tgt = tgt;
            ms    = S_CONF;
        end else if (st && (ms == S_CONF || ms == S_DONE)) begin
            ms = S_RUN;
            m_bits.delete();
            m_cnt = 0;
        end else if (ms == S_RUN) begin
            if (ab) begin
                ms = S_CONF;
            end else if (v) begin
                m_bits.push_back(b);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                if (model_hit()) begin
                    if (m_cnt < 255) m_cnt++;
                    exp_cyc_q.push_back(cyc + 1);
                    exp_cnt_q.push_back(m_cnt);
                    if (m_tgt != 0 && m_cnt == m_tgt) ms = S_DONE;
                end
            end
        end
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        check("cfg_err", int'(cfg_err), int'(err));
        check("busy", int'(busy), int'(ms == S_RUN));
        check("done", int'(done), int'(ms == S_DONE));
        check("cfg_ready", int'(cfg_ready), int'(ms != S_RUN));
        check("match_count", int'(match_count), m_cnt);
    endtask

    task automatic configure(logic [7:0] pat, int len, int tgt);
        step(1'b1, pat, len, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go();
        step(1'b0, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(bit b, bit v);
        step(1'b0, 8'h00, 0, 0, 1'b0, 1'b0, b, v);
    endtask

    task automatic send_stream(logic [15:0] bits, int n, bit gaps);
        logic [15:0] s;
        s = bits;
        for (int i = n - 1; i >= 0; i--) begin
            send(s[i], 1'b1);
            if (gaps) send(~s[i], 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_match_count", int'(match_count), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        ms = S_IDLE;
        m_pat = '0;
        m_len = 0;
        m_tgt = 0;
        m_cnt = 0;
        m_bits.delete();
        exp_cyc_q.delete();
        exp_cnt_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        go();

        configure(8'b1000, 4, 2);
        go();
        send_stream(16'b11_0001_0001, 10, 1'b0);
        check("t1_count", int'(match_count), 2);
        check("t1_done", int'(done), 1);

        configure(8'b101, 3, 0);
        go();
        send_stream(16'b10101, 5, 1'b0);
        check("overlap_busy", int'(busy), 1);

        step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        go();
        send_stream(16'b10101, 5, 1'b1);
        check("gap_count", int'(match_count), 2);

        step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        configure(8'b11, 2, 0);
        go();
        send(1'b1, 1'b1);
        step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        configure(8'b1, 1, 1);
        go();
        step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        step(1'b1, 8'h05, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        do_reset();
        configure(8'h01, 0, 0);
        configure(8'h01, MAX_LEN + 1, 0);
        go();
        send(1'b1, 1'b1);

        configure(8'h01, 1, 0);
        go();
        repeat (300) send(1'b1, 1'b1);
        check("sat_count", int'(match_count), 255);

        for (int r = 0; r < 8; r++) begin
            configure(8'($urandom), $urandom_range(1, MAX_LEN), $urandom_range(0, 4));
            go();
            for (int k = 0; k < 80; k++) begin
                step(($urandom % 25) == 0, 8'($urandom), $urandom_range(0, MAX_LEN + 1),
                     $urandom_range(0, 4), ($urandom % 12) == 0, ($urandom % 40) == 0,
                     1'($urandom), ($urandom % 4) != 0);
            end
        end

        do_reset();
        configure(8'b1, 1, 0);
        go();
        repeat (3) send(1'b1, 1'b1);
        check("pre_reset_count", int'(match_count), 3);
        @(negedge clock);
        #2;
        do_reset();
        go();

        repeat (3) @(posedge clock);
        #1;
        check("sb_drain", exp_cyc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
